io_uart_responder: RTL and testbench

- Memory-mapped UART peripheral on the CPU's external data/IO bus; responder end of the strobe/ready protocol the core drives (addr, write data, write strobe, read strobe -> read data, ready).
- Decodes a fixed address window and serves DATA, STATUS and DIVISOR registers.
- Transmit side: TX FIFO feeding an 8N1 serializer. Receive side: 8N1 deserializer with a single holding register.

---
 rtl/io_map_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/io_uart_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_io_uart_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared IO map definitions: UART window base, register offsets, STATUS bit indices,
// UART FSM state types and the effective-divisor helper.
package io_map_pkg;

  localparam logic [63:0] UART_BASE_ADDR = 64'hFFFF_FFFF_FFFF_F000;

  localparam logic [7:0] OFF_DATA    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_DIVISOR = 8'h10;

  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_RX_VALID    = 2;
  localparam int unsigned ST_RX_OVERRUN  = 3;
  localparam int unsigned ST_TX_BUSY     = 4;
  localparam int unsigned ST_TX_OVERFLOW = 5;
  localparam int unsigned ST_FRAME_ERR   = 6;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Divisors below 2 would leave no room for a mid-bit sample.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_next;
  logic             do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/io_uart_responder.sv
// Memory-mapped 8N1 UART responder: DATA/STATUS/DIVISOR registers, TX FIFO + serializer,
// RX deserializer with a single holding register.
module io_uart_responder
  import io_map_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = UART_BASE_ADDR,
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] bus_addr,
  input  logic [63:0] bus_wdata,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic [63:0] bus_rdata,
  output logic        bus_ready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  logic [7:0]  off;
  logic        hit, wr_hit, rd_hit;
  logic        data_wr, data_rd, stat_wr, div_wr;
  logic [15:0] divisor;
  logic [7:0]  rx_byte, rx_shift, fifo_rdata;
  logic        rx_valid, rx_overrun, tx_overflow, frame_err;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_deliver;
  logic [63:0] rd_val;
  logic        unused_bits;

  tx_state_e   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  rx_state_e   rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;

  assign unused_bits = ^{bus_addr[2:0], bus_wdata[63:16]};

  assign hit     = bus_addr[63:8] == BASE_ADDR[63:8];
  assign off     = {bus_addr[7:3], 3'b000};
  assign wr_hit  = hit & bus_write;
  assign rd_hit  = hit & bus_read & ~bus_write;
  assign data_wr = wr_hit & (off == OFF_DATA);
  assign data_rd = rd_hit & (off == OFF_DATA);
  assign stat_wr = wr_hit & (off == OFF_STATUS);
  assign div_wr  = wr_hit & (off == OFF_DIVISOR);
  assign irq     = rx_valid;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_wr),
    .wdata (bus_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA:    rd_val[7:0]  = rx_byte;
      OFF_STATUS: begin
        rd_val[ST_TX_FULL]     = fifo_full;
        rd_val[ST_TX_EMPTY]    = fifo_empty;
        rd_val[ST_RX_VALID]    = rx_valid;
        rd_val[ST_RX_OVERRUN]  = rx_overrun;
        rd_val[ST_TX_BUSY]     = tx_state != TxIdle;
        rd_val[ST_TX_OVERFLOW] = tx_overflow;
        rd_val[ST_FRAME_ERR]   = frame_err;
      end
      OFF_DIVISOR: rd_val[15:0] = divisor;
      default:     rd_val       = '0;
    endcase
  end

  // Sticky bits: a set event in the same cycle as a W1C write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready   <= 1'b0;
      bus_rdata   <= '0;
      divisor     <= DEFAULT_DIV;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      bus_ready <= hit & (bus_read | bus_write);
      bus_rdata <= rd_hit ? rd_val : '0;
      if (div_wr) divisor <= bus_wdata[15:0];
      if (rx_deliver) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end
      rx_overrun  <= (rx_overrun & ~(stat_wr & bus_wdata[ST_RX_OVERRUN])) |
                     (rx_deliver & rx_valid & ~data_rd);
      tx_overflow <= (tx_overflow & ~(stat_wr & bus_wdata[ST_TX_OVERFLOW])) |
                     (data_wr & fifo_full & ~fifo_pop);
      frame_err   <= (frame_err & ~(stat_wr & bus_wdata[ST_FRAME_ERR])) |
                     (rx_deliver & ~rx_s2);
    end
  end

  assign tx_bit_end = tx_cnt == tx_div - 16'd1;
  assign fifo_pop   = ~fifo_empty &
                      ((tx_state == TxIdle) | ((tx_state == TxStop) & tx_bit_end));

  // A pending byte at the end of STOP goes straight to START, leaving no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_div   <= 16'd2;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_cnt <= tx_bit_end ? 16'd0 : tx_cnt + 16'd1;
      case (tx_state)
        TxIdle: begin
          tx_cnt <= '0;
          if (fifo_pop) begin
            tx_state <= TxStart;
            tx_shift <= fifo_rdata;
            tx_div   <= eff_div(divisor);
            uart_tx  <= 1'b0;
          end
        end
        TxStart: if (tx_bit_end) begin
          tx_state <= TxData;
          tx_bit   <= '0;
          uart_tx  <= tx_shift[0];
        end
        TxData: if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            tx_state <= TxStop;
            uart_tx  <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            uart_tx  <= tx_shift[1];
          end
        end
        TxStop: if (tx_bit_end) begin
          if (fifo_pop) begin
            tx_state <= TxStart;
            tx_shift <= fifo_rdata;
            tx_div   <= eff_div(divisor);
            uart_tx  <= 1'b0;
          end else begin
            tx_state <= TxIdle;
          end
        end
        default: tx_state <= TxIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall    = rx_prev & ~rx_s2;
  assign rx_deliver = (rx_state == RxStop) & (rx_cnt == rx_div - 16'd1);

  // Start is checked half a period in, so data/stop samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_div   <= 16'd2;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= rx_cnt + 16'd1;
      case (rx_state)
        RxIdle: begin
          rx_cnt <= '0;
          if (rx_fall) begin
            rx_state <= RxStart;
            rx_div   <= eff_div(divisor);
          end
        end
        RxStart: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RxIdle : RxData;
        end
        RxData: if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RxStop;
        end
        RxStop: if (rx_deliver) begin
          rx_cnt   <= '0;
          rx_state <= RxIdle;
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed/randomized bench for io_uart_responder with a frame-level serial monitor.
module tb_io_uart_responder;

  localparam logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_F000;
  localparam logic [63:0] A_DAT = BASE + 64'h00;
  localparam logic [63:0] A_STA = BASE + 64'h08;
  localparam logic [63:0] A_DIV = BASE + 64'h10;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] bus_addr = '0;
  logic [63:0] bus_wdata = '0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [63:0] bus_rdata;
  logic        bus_ready;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int mon_div = 4;
  bit mon_en = 1'b0;
  logic [7:0] got_tx[$];

  always #5 clk = ~clk;

  io_uart_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_write (bus_write),
    .bus_read  (bus_read),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic rd, input logic [63:0] addr,
                     input logic [63:0] wdata, output logic [63:0] rdata, output logic rdy);
    @(posedge clk); #1;
    bus_addr = addr; bus_wdata = wdata; bus_write = wr; bus_read = rd;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_read = 1'b0;
    rdata = bus_rdata; rdy = bus_ready;
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    logic [63:0] d; logic r;
    bus(1'b0, 1'b1, addr, '0, d, r);
    check({tag, "_rdy"}, {63'd0, r}, 64'd1);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] wdata);
    logic [63:0] d; logic r;
    bus(1'b1, 1'b0, addr, wdata, d, r);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] fb;
    fb = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      uart_rx = fb[k];
      repeat (div) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (2 * div) @(posedge clk);
    #1;
  endtask

  // Decodes 8N1 frames on uart_tx by sampling each bit in its middle.
  initial begin : tx_mon
    logic [9:0] fr;
    forever begin
      @(posedge clk); #2;
      if (mon_en && uart_tx === 1'b0) begin
        repeat (mon_div / 2) @(posedge clk);
        #2 fr[0] = uart_tx;
        for (int k = 1; k < 10; k++) begin
          repeat (mon_div) @(posedge clk);
          #2 fr[k] = uart_tx;
        end
        if (fr[0] == 1'b0 && fr[9] == 1'b1) got_tx.push_back(fr[8:1]);
      end
    end
  end

  initial begin : stim
    logic [63:0] d;
    logic        r;
    logic [7:0]  b0, b1, b2, b3;
    logic [9:0]  fb;
    logic [7:0]  wbytes[10];
    logic [7:0]  exp_q[$];
    int          waited;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus_rdata, 64'd0);
    check("rst_ready", {63'd0, bus_ready}, 64'd0);
    check("rst_tx", {63'd0, uart_tx}, 64'd1);
    check("rst_irq", {63'd0, irq}, 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    rd_chk("status_rst", A_STA, 64'h2);
    @(posedge clk); #1;
    check("ready_one_cycle", {63'd0, bus_ready}, 64'd0);
    rd_chk("div_rst", A_DIV, 64'd868);
    rd_chk("off20", BASE + 64'h20, 64'd0);
    bus(1'b0, 1'b1, BASE + 64'h100, '0, d, r);
    check("miss_rdy", {63'd0, r}, 64'd0);

    // Write and read together: write wins, rdata is zero, upper divisor bits dropped.
    bus(1'b1, 1'b1, A_DIV, 64'hDEAD_0000_ABCD_0004, d, r);
    check("rw_rdy", {63'd0, r}, 64'd1);
    check("rw_rdata", d, 64'd0);
    rd_chk("div4", A_DIV, 64'h4);

    // TX frame waveform at divisor 4.
    mon_div = 4;
    got_tx.delete();
    wr(A_DAT, 64'h1A5);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    check("tx_start_seen", {63'd0, uart_tx}, 64'd0);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx_wave%0d", i), {63'd0, uart_tx}, {63'd0, fb[i / 4]});
      @(posedge clk); #1;
    end
    check("tx_after", {63'd0, uart_tx}, 64'd1);
    rd_chk("status_tx_done", A_STA, 64'h2);

    b0 = 8'($urandom);
    wr(A_DAT, {56'd0, b0});
    repeat (5) @(posedge clk);
    rd_chk("status_busy", A_STA, 64'h12);
    waited = 0;
    while (got_tx.size() < 2 && waited < 200) begin
      @(posedge clk); waited++;
    end
    check("tx_frames2", got_tx.size(), 2);
    check("tx_byte0", (got_tx.size() > 0) ? {56'd0, got_tx[0]} : 'x, 64'hA5);
    check("tx_byte1", (got_tx.size() > 1) ? {56'd0, got_tx[1]} : 'x, {56'd0, b0});

    // Overflow: one byte leaves for the serializer, DEPTH are queued, the rest are dropped.
    wr(A_DIV, 64'd2);
    mon_div = 2;
    repeat (30) @(posedge clk);
    got_tx.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      wbytes[i] = 8'($urandom);
      if (i < DEPTH + 1) exp_q.push_back(wbytes[i]);
    end
    @(posedge clk); #1;
    bus_addr = A_DAT; bus_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_wdata = {56'd0, wbytes[i]};
      @(posedge clk); #1;
    end
    bus_write = 1'b0;
    waited = 0;
    while (got_tx.size() < exp_q.size() && waited < 800) begin
      @(posedge clk); waited++;
    end
    repeat (40) @(posedge clk);
    check("ovf_count", got_tx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("ovf_byte%0d", i),
            (i < got_tx.size()) ? {56'd0, got_tx[i]} : 'x, {56'd0, exp_q[i]});
    rd_chk("status_ovf", A_STA, 64'h22);
    wr(A_STA, 64'h20);
    rd_chk("status_ovf_clr", A_STA, 64'h2);

    // RX at divisor 8.
    wr(A_DIV, 64'd8);
    b1 = 8'h3C;
    send_rx(b1, 1'b1, 8);
    check("rx_irq", {63'd0, irq}, 64'd1);
    rd_chk("rx_data", A_DAT, {56'd0, b1});
    check("rx_irq_clr", {63'd0, irq}, 64'd0);

    b1 = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b1, 1'b1, 8);
    send_rx(b2, 1'b1, 8);
    rd_chk("status_overrun", A_STA, 64'h0E);
    rd_chk("overrun_data", A_DAT, {56'd0, b2});
    wr(A_STA, 64'h08);
    rd_chk("status_overrun_clr", A_STA, 64'h2);

    b3 = 8'($urandom);
    send_rx(b3, 1'b0, 8);
    rd_chk("status_frame_err", A_STA, 64'h46);
    rd_chk("frame_err_data", A_DAT, {56'd0, b3});
    wr(A_STA, 64'h40);
    rd_chk("status_fe_clr", A_STA, 64'h2);

    @(posedge clk); #1 uart_rx = 1'b0;
    @(posedge clk); #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_irq", {63'd0, irq}, 64'd0);
    rd_chk("glitch_status", A_STA, 64'h2);

    // Reset during data bit 3 (0xA5 bit 3 is 0, so the line must visibly jump high).
    wr(A_DIV, 64'd4);
    wr(A_DAT, 64'hA5);
    mon_en = 1'b0;
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    repeat (17) @(posedge clk);
    #1;
    check("mid_bit3", {63'd0, uart_tx}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {63'd0, uart_tx}, 64'd1);
    check("async_rst_ready", {63'd0, bus_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_chk("status_after_rst", A_STA, 64'h2);
    rd_chk("div_after_rst", A_DIV, 64'd868);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
